md_unit: RTL and testbench

Multiply/divide unit with architectural HI/LO registers for the MIPS core. It executes MULT/MULTU/DIV/DIVU and the MTHI/MTLO writes issued from EX. It holds HI/LO and drives the HI/LO read value consumed by the EX result select for MFHI/MFLO. It raises `md_busy` so the hazard unit stalls any later HI/LO access or new mult/div until the result is committed.

---
 rtl/md_pkg.sv | 35 +++
 rtl/md_div_step.sv | 28 ++
 rtl/md_unit.sv | 146 ++++++++++++++
 tb/tb_md_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// divider sizing and divide-by-zero result constants.
package md_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_ITERS + 1);

  localparam logic [XLEN-1:0] DIV0_QUO = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL1 = 3'd1,
    S_MUL2 = 3'd2,
    S_DIV  = 3'd3,
    S_DFIX = 3'd4
  } md_state_e;

  // Two's-complement negate when neg is set.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + XLEN'(1)) : x;
  endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// remainder, subtract the divisor if it fits, and shift in a quotient bit.
module md_div_step
  import md_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nx,
  output logic [XLEN-1:0] quo_nx
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[XLEN]) begin
      rem_nx = shifted[XLEN-1:0];
      quo_nx = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_nx = diff[XLEN-1:0];
      quo_nx = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/md_unit.sv
// MIPS multiply/divide unit: HI/LO registers, 2-cycle multiplier and
// 32-iteration restoring divider with busy handshake to the hazard unit.
module md_unit
  import md_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            md_start,
  input  logic [2:0]      md_op,
  input  logic            md_cancel,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            rhl_sel,
  output logic [XLEN-1:0] rhl_out,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out,
  output logic            md_busy
);

  md_state_e state, state_nx;
  md_op_e    op_c;
  logic      start_c;
  logic      is_signed_c;

  logic [XLEN-1:0]        hi_q, lo_q;
  logic                   busy_q;
  logic signed [XLEN:0]   mul_a, mul_b;
  logic [2*XLEN-1:0]      prod;
  logic [XLEN-1:0]        rem, quo, dvs;
  logic [XLEN-1:0]        rem_nx_c, quo_nx_c;
  logic [CNT_W-1:0]       cnt;
  logic                   q_neg, r_neg, div_zero;

  assign op_c        = md_op_e'(md_op);
  assign is_signed_c = (op_c == OP_MULT) || (op_c == OP_DIV);

  md_div_step u_div_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dvs),
    .rem_nx  (rem_nx_c),
    .quo_nx  (quo_nx_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; cancel from any busy state returns to IDLE.
  always_comb begin
    state_nx = state;
    start_c  = (state == S_IDLE) && md_start && !md_cancel;
    if (md_cancel && (state != S_IDLE)) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_c) begin
            case (op_c)
              OP_MULT, OP_MULTU: state_nx = S_MUL1;
              OP_DIV, OP_DIVU:   state_nx = S_DIV;
              default:           state_nx = S_IDLE;
            endcase
          end
        end
        S_MUL1:  state_nx = S_MUL2;
        S_MUL2:  state_nx = S_IDLE;
        S_DIV:   if (cnt == CNT_W'(DIV_ITERS - 1)) state_nx = S_DFIX;
        S_DFIX:  state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Datapath; HI/LO only change on MTHI/MTLO or an uncancelled commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      busy_q <= (state_nx != S_IDLE);
      case (state)
        S_IDLE: begin
          if (start_c) begin
            case (op_c)
              OP_MULT, OP_MULTU: begin
                mul_a <= {is_signed_c & rs_val[XLEN-1], rs_val};
                mul_b <= {is_signed_c & rt_val[XLEN-1], rt_val};
              end
              OP_DIV, OP_DIVU: begin
                rem      <= '0;
                quo      <= neg_if(rs_val, is_signed_c & rs_val[XLEN-1]);
                dvs      <= neg_if(rt_val, is_signed_c & rt_val[XLEN-1]);
                cnt      <= '0;
                q_neg    <= is_signed_c & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
                r_neg    <= is_signed_c & rs_val[XLEN-1];
                div_zero <= (rt_val == '0);
              end
              OP_MTHI: hi_q <= rs_val;
              OP_MTLO: lo_q <= rs_val;
              default: ;
            endcase
          end
        end
        S_MUL1: prod <= 64'(mul_a) * 64'(mul_b);
        S_MUL2: begin
          if (!md_cancel) begin
            hi_q <= prod[2*XLEN-1:XLEN];
            lo_q <= prod[XLEN-1:0];
          end
        end
        S_DIV: begin
          rem <= rem_nx_c;
          quo <= quo_nx_c;
          cnt <= cnt + CNT_W'(1);
        end
        S_DFIX: begin
          // Divide by zero leaves |rs| in the remainder, so the sign fix restores rs.
          if (!md_cancel) begin
            hi_q <= neg_if(rem, r_neg);
            lo_q <= div_zero ? DIV0_QUO : neg_if(quo, q_neg);
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_out  = hi_q;
  assign lo_out  = lo_q;
  assign md_busy = busy_q;
  assign rhl_out = rhl_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, cancel/reset
// sequences and randomized operations against an arithmetic reference model.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        md_start;
  logic [2:0]  md_op;
  logic        md_cancel;
  logic [31:0] rs_val, rt_val;
  logic        rhl_sel;
  logic [31:0] rhl_out, hi_out, lo_out;
  logic        md_busy;

  int n_tests = 0;
  int n_fail  = 0;

  md_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_start  (md_start),
    .md_op     (md_op),
    .md_cancel (md_cancel),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .rhl_sel   (rhl_sel),
    .rhl_out   (rhl_out),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .md_busy   (md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          nbusy;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then count busy cycles (bounded) until commit.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy);
    md_op = op; rs_val = a; rt_val = b; md_start = 1'b1;
    step();
    md_start = 1'b0; md_op = 3'b000;
    nbusy = 0;
    while (md_busy && nbusy < 100) begin
      step();
      nbusy++;
    end
  endtask

  // Reference model written from the architectural rules.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi_in, input logic [31:0] lo_in,
                       output logic [31:0] hi, output logic [31:0] lo, output int nbusy);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    hi = hi_in; lo = lo_in; nbusy = 0;
    sa = $signed(a); sb = $signed(b);
    case (op)
      3'b001: begin sp = longint'(sa) * longint'(sb); hi = sp[63:32]; lo = sp[31:0]; nbusy = 2; end
      3'b010: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; nbusy = 2; end
      3'b011: begin
        nbusy = 33;
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 0; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      3'b100: begin
        nbusy = 33;
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      3'b101: hi = a;
      3'b110: lo = a;
      default: ;
    endcase
  endtask

  initial begin
    int          nb;
    logic [31:0] mh, ml, eh, el;
    int          eb;

    rst_n = 1'b0; md_start = 1'b0; md_op = 3'b000; md_cancel = 1'b0;
    rs_val = '0; rt_val = '0; rhl_sel = 1'b0;
    repeat (2) step();
    check("reset_hi", hi_out, 32'h0);
    check("reset_lo", lo_out, 32'h0);
    check("reset_busy", 32'(md_busy), 32'h0);
    check("reset_rhl", rhl_out, 32'h0);
    rst_n = 1'b1;
    step();

    vecs[0] = '{OP_MTHI,  32'h1234_5678, 32'h0,          32'h1234_5678, 32'h0,          0};
    vecs[1] = '{OP_MTLO,  32'h9ABC_DEF0, 32'h0,          32'h1234_5678, 32'h9ABC_DEF0, 0};
    vecs[2] = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2};
    vecs[3] = '{OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 2};
    vecs[4] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[5] = '{OP_DIVU,  32'd100,       32'd7,          32'd2,          32'd14,         33};
    vecs[6] = '{OP_DIVU,  32'd5,         32'd0,          32'd5,          32'hFFFF_FFFF, 33};
    vecs[7] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,          32'h8000_0000, 33};

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, nb);
      check($sformatf("vec%0d_busy", i), 32'(nb), 32'(vecs[i].nbusy));
      check($sformatf("vec%0d_hi", i), hi_out, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo_out, vecs[i].lo);
      rhl_sel = 1'b1; #1;
      check($sformatf("vec%0d_rhl_hi", i), rhl_out, vecs[i].hi);
      rhl_sel = 1'b0; #1;
      check($sformatf("vec%0d_rhl_lo", i), rhl_out, vecs[i].lo);
    end

    // Cancel mid-divide; the start issued with the cancel is dropped.
    run_op(OP_MTHI, 32'h1111_1111, 32'h0, nb);
    run_op(OP_MTLO, 32'h1111_1111, 32'h0, nb);
    md_op = OP_DIV; rs_val = 32'd1000; rt_val = 32'd3; md_start = 1'b1;
    step();
    md_start = 1'b0;
    repeat (9) step();
    check("cancel_busy_before", 32'(md_busy), 32'h1);
    md_cancel = 1'b1; md_start = 1'b1; md_op = OP_MTHI; rs_val = 32'h2222_2222;
    step();
    check("cancel_busy_after", 32'(md_busy), 32'h0);
    check("cancel_hi", hi_out, 32'h1111_1111);
    check("cancel_lo", lo_out, 32'h1111_1111);
    md_op = OP_MTLO;
    step();
    check("cancel_idle_mtlo_dropped", lo_out, 32'h1111_1111);
    check("cancel_idle_busy", 32'(md_busy), 32'h0);
    md_cancel = 1'b0; md_start = 1'b0;
    repeat (3) step();
    check("cancel_no_late_commit_hi", hi_out, 32'h1111_1111);

    // MTLO then MULTU; MTHI issued while busy must be ignored.
    run_op(OP_MTLO, 32'hDEAD_BEEF, 32'h0, nb);
    check("mtlo_lo", lo_out, 32'hDEAD_BEEF);
    check("mtlo_no_busy", 32'(nb), 32'h0);
    md_op = OP_MULTU; rs_val = 32'd2; rt_val = 32'd3; md_start = 1'b1;
    step();
    md_op = OP_MTHI; rs_val = 32'h5555_5555;
    check("multu_busy_c1", 32'(md_busy), 32'h1);
    check("multu_lo_hold_c1", lo_out, 32'hDEAD_BEEF);
    step();
    md_start = 1'b0; md_op = 3'b000;
    check("multu_busy_c2", 32'(md_busy), 32'h1);
    check("multu_lo_hold_c2", lo_out, 32'hDEAD_BEEF);
    step();
    check("multu_busy_done", 32'(md_busy), 32'h0);
    check("multu_lo", lo_out, 32'd6);
    check("multu_hi", hi_out, 32'd0);
    repeat (2) step();
    check("busy_mthi_ignored", hi_out, 32'd0);

    // Asynchronous reset in the middle of a divide.
    run_op(OP_MTHI, 32'hA5A5_A5A5, 32'h0, nb);
    md_op = OP_DIV; rs_val = 32'd77; rt_val = 32'd5; md_start = 1'b1;
    step();
    md_start = 1'b0;
    repeat (14) step();
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(md_busy), 32'h0);
    check("arst_hi", hi_out, 32'h0);
    check("arst_lo", lo_out, 32'h0);
    #7 rst_n = 1'b1;
    step();
    run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, nb);
    check("post_rst_busy", 32'(nb), 32'd33);
    check("post_rst_lo", lo_out, 32'hFFFF_FFF2);
    check("post_rst_hi", hi_out, 32'hFFFF_FFFE);

    // Randomized operations against the reference model.
    mh = hi_out === 32'hFFFF_FFFE ? 32'hFFFF_FFFE : 32'hFFFF_FFFE;
    ml = 32'hFFFF_FFF2;
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(1, 6));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      model(op, a, b, mh, ml, eh, el, eb);
      run_op(op, a, b, nb);
      check($sformatf("rnd%0d_op%0d_busy", i, op), 32'(nb), 32'(eb));
      check($sformatf("rnd%0d_op%0d_hi a=%h b=%h", i, op, a, b), hi_out, eh);
      check($sformatf("rnd%0d_op%0d_lo a=%h b=%h", i, op, a, b), lo_out, el);
      mh = eh; ml = el;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
